sdp_mcif_rd_responder: RTL and testbench
========================================

SDP_MCIF_RD_RESPONDER -- requirements
Module: sdp_mcif_rd_responder

Interface
REQ-001 Parameter LAT_DEPTH, default 16, SHALL set the latency-FIFO credit pool in beats (legal range 2..255).
REQ-002 Parameter MEM_AW, default 16, SHALL set the backing-SRAM word-address width.
REQ-003 nvdla_core_clk  in  1  sole clock; every flop is rising-edge.
REQ-004 nvdla_core_rst  in  1  reset, asynchronous and active-high.
REQ-005 sdp2mcif_rd_req_valid / sdp2mcif_rd_req_ready  in / out  1 / 1  request handshake.
REQ-006 sdp2mcif_rd_req_pd  in  47  request payload: [31:0] byte address (8B aligned), [46:32] size in beats minus one.
REQ-007 mcif2sdp_rd_rsp_valid / mcif2sdp_rd_rsp_ready  out / in  1 / 1  response handshake.
REQ-008 mcif2sdp_rd_rsp_pd  out  65  response payload: [63:0] data, [64] mask (always 1 for a data beat).
REQ-009 sdp2mcif_rd_cdt_lat_fifo_pop  in  1  one credit returned per cycle high.
REQ-010 mem_rd_en / mem_rd_addr / mem_rd_data  out / out / in  1 / MEM_AW / 64  synchronous SRAM read port, data valid exactly 1 cycle after mem_rd_en.
REQ-011 rsp_busy  out  1  high while any request is accepted but not fully returned.

Function
REQ-012 Request input SHALL be a 2-entry FIFO; req_ready = not full; simultaneous push and pop when full SHALL NOT be accepted.
REQ-013 Beat generator FSM SHALL have states IDLE and ISSUE; IDLE->ISSUE when request FIFO non-empty, loading base = addr[MEM_AW+2:3] and beat counter = size.
REQ-014 In ISSUE, one mem_rd_en per cycle SHALL be asserted iff credit > 0 and output-buffer free slots exceed reads in flight.
REQ-015 mem_rd_addr SHALL equal base plus beat index, modulo 2^MEM_AW (wrap silently).
REQ-016 On the issue of beat index == size, the FIFO entry SHALL pop and FSM SHALL go to IDLE, or reload directly from the next entry in the same cycle if present (no bubble).
REQ-017 Credit counter (width clog2(LAT_DEPTH+1)) SHALL reset to LAT_DEPTH, decrement per issued beat, increment per pop; issue and pop in the same cycle SHALL leave it unchanged.
REQ-018 A pop while credit == LAT_DEPTH SHALL be ignored (saturate) and flagged by an assertion.
REQ-019 Returned SRAM data SHALL enter a 2-entry output buffer with mask=1; rsp_valid = buffer non-empty; first beat of a request appears at the output 2 cycles after req accept, best case.
REQ-020 Beats SHALL leave in issue order; no reordering between requests.
REQ-021 Output pd SHALL be held stable while valid && !ready.
REQ-022 size = 0 SHALL produce exactly one beat; size = 0x7FFF SHALL produce 32768 beats without counter overflow.
REQ-023 rsp_busy SHALL be low only when request FIFO, FSM, in-flight read and output buffer are all empty.

Reset
REQ-024 Under reset: req_ready=0, rsp_valid=0, rsp_pd=0, mem_rd_en=0, mem_rd_addr=0, rsp_busy=0, FSM=IDLE, credit=LAT_DEPTH, both FIFOs empty.
REQ-025 Reset asserted mid-burst SHALL discard all pending beats and credits immediately; no beat SHALL emerge after deassertion without a new request.
REQ-026 req_ready SHALL rise the first cycle after reset deassertion.

Structure
REQ-027 Payload field offsets (addr, size, data, mask) and widths 47/65 SHALL live in shared package sdp_mcif_pkg.
REQ-028 One sub-module is natural: sdp_mcif_fifo2, the 2-entry valid/ready FIFO, instanced for request and response buffers.

Verification
REQ-029 Single req addr=0x100, size=0, ready held high -> one beat, mem_rd_addr=0x20, mask=1, valid 2 cycles after accept.
REQ-030 Req size=7 with LAT_DEPTH=4, no pops -> exactly 4 beats issued then stall; pulse pop 4 times -> remaining 4 beats delivered.
REQ-031 Back-to-back reqs size=3 then size=1, ready always high -> 6 consecutive beats, no bubble, in order.
REQ-032 rsp_ready toggled 1-0 pseudo-randomly over size=15 burst -> 16 beats, no loss/duplication, pd stable while stalled.
REQ-033 addr=(2^MEM_AW-2)*8, size=3 -> mem_rd_addr sequence 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-034 Reset asserted after 3 beats of a size=9 burst -> outputs at reset values, credit=LAT_DEPTH, no further beats after release.

Source files
------------

// File: rtl/sdp_mcif_pkg.sv
// Shared payload layout for the SDP read-response path (request/response pd fields).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package sdp_mcif_pkg;

    // Request pd: [31:0] byte address, [46:32] beats minus one
    localparam int REQ_ADDR_W = 32;
    localparam int REQ_SIZE_W = 15;
    localparam int REQ_PD_W   = REQ_SIZE_W + REQ_ADDR_W;   // 47

    // Response pd: [63:0] data, [64] mask
    localparam int RSP_DATA_W = 64;
    localparam int RSP_PD_W   = RSP_DATA_W + 1;            // 65

    // Packed MSB-first, so field offsets match the pd bit positions above
    typedef struct packed {
        logic [REQ_SIZE_W-1:0] size;
        logic [REQ_ADDR_W-1:0] addr;
    } req_t;

    typedef struct packed {
        logic                  mask;
        logic [RSP_DATA_W-1:0] data;
    } rsp_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } beat_state_e;

endpackage

// File: rtl/sdp_mcif_fifo2.sv
// Two-entry valid/ready FIFO used for the request and response buffers.
// Latency: 1 cycle push to pop_valid; pop_data is registered storage, stable until popped.
// Backpressure: push_ready = not full; a push while full is refused even if a pop happens the same cycle.
// Ports: clk/rst, push_valid/push_ready/push_data, pop_valid/pop_ready/pop_data, count (0..2 entries).
module sdp_mcif_fifo2 #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data,
    output logic [1:0]   count
);

    logic [W-1:0] slot0;
    logic [W-1:0] slot1;
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign push_ready = (count != 2'd2);
    assign pop_valid  = (count != 2'd0);
    assign do_push    = push_valid && push_ready;
    assign do_pop     = pop_valid && pop_ready;
    assign pop_data   = rd_ptr ? slot1 : slot0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0  <= '0;
            slot1  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                if (wr_ptr) slot1 <= push_data;
                else        slot0 <= push_data;
                wr_ptr <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/sdp_mcif_rd_responder.sv
// SDP read responder: splits burst requests into SRAM beat reads and returns data beats in order.
// Latency: first beat valid 2 cycles after request accept (best case); one beat per cycle sustained.
// Backpressure: issue stalls on zero latency-FIFO credit or a full output buffer; request side is a 2-deep FIFO.
// Ports: nvdla_core_clk/nvdla_core_rst, sdp2mcif_rd_req_* (request in), mcif2sdp_rd_rsp_* (beats out),
//        sdp2mcif_rd_cdt_lat_fifo_pop (credit return), mem_rd_* (sync SRAM read port), rsp_busy.
module sdp_mcif_rd_responder
    import sdp_mcif_pkg::*;
#(
    parameter int LAT_DEPTH = 16,
    parameter int MEM_AW    = 16
) (
    input  logic                nvdla_core_clk,
    input  logic                nvdla_core_rst,
    input  logic                sdp2mcif_rd_req_valid,
    output logic                sdp2mcif_rd_req_ready,
    input  logic [REQ_PD_W-1:0] sdp2mcif_rd_req_pd,
    output logic                mcif2sdp_rd_rsp_valid,
    input  logic                mcif2sdp_rd_rsp_ready,
    output logic [RSP_PD_W-1:0] mcif2sdp_rd_rsp_pd,
    input  logic                sdp2mcif_rd_cdt_lat_fifo_pop,
    output logic                mem_rd_en,
    output logic [MEM_AW-1:0]   mem_rd_addr,
    input  logic [63:0]         mem_rd_data,
    output logic                rsp_busy
);

    localparam int CW = $clog2(LAT_DEPTH + 1);

    beat_state_e           state;
    logic [REQ_SIZE_W-1:0] beat_idx;
    logic [CW-1:0]         credit;
    logic                  rd_pending;   // SRAM read issued last cycle, data arrives this cycle
    logic                  init_done;    // holds req_ready low for the first cycle out of reset

    // Request FIFO
    logic       rq_push_valid;
    logic       rq_push_ready;
    logic       rq_valid;
    logic       rq_pop;
    logic [1:0] rq_count;
    req_t       rq_head;

    // Response FIFO
    rsp_t       rsp_beat;
    logic       rsp_push_ready;
    logic       rsp_pop;
    logic [1:0] rsp_count;
    logic [2:0] rsp_free;

    logic issue;
    logic last_beat;
    logic room;
    logic pop_eff;
    logic rq_next_nonempty;
    logic unused_addr_bits;

    assign rq_push_valid         = sdp2mcif_rd_req_valid && init_done;
    assign sdp2mcif_rd_req_ready = rq_push_ready && init_done;

    sdp_mcif_fifo2 #(.W(REQ_PD_W)) u_req_fifo (
        .clk        (nvdla_core_clk),
        .rst        (nvdla_core_rst),
        .push_valid (rq_push_valid),
        .push_ready (rq_push_ready),
        .push_data  (sdp2mcif_rd_req_pd),
        .pop_valid  (rq_valid),
        .pop_ready  (rq_pop),
        .pop_data   (rq_head),
        .count      (rq_count)
    );

    assign rsp_beat.mask = 1'b1;
    assign rsp_beat.data = mem_rd_data;

    sdp_mcif_fifo2 #(.W(RSP_PD_W)) u_rsp_fifo (
        .clk        (nvdla_core_clk),
        .rst        (nvdla_core_rst),
        .push_valid (rd_pending),
        .push_ready (rsp_push_ready),
        .push_data  (rsp_beat),
        .pop_valid  (mcif2sdp_rd_rsp_valid),
        .pop_ready  (mcif2sdp_rd_rsp_ready),
        .pop_data   (mcif2sdp_rd_rsp_pd),
        .count      (rsp_count)
    );

    assign rsp_pop = mcif2sdp_rd_rsp_valid && mcif2sdp_rd_rsp_ready;

    // Slots free at the next edge must exceed reads already in flight. Counting
    // this cycle's pop keeps a back-to-back stream running without a bubble.
    assign rsp_free = 3'd2 - {1'b0, rsp_count} + {2'b0, rsp_pop};
    assign room     = rsp_free > {2'b0, rd_pending};

    // The FIFO head is the active request; IDLE with a non-empty FIFO issues
    // beat 0 straight away so the first beat is not delayed by the state change.
    assign issue     = rq_valid && (credit != '0) && room;
    assign last_beat = (beat_idx == rq_head.size);
    assign rq_pop    = issue && last_beat;

    assign mem_rd_en   = issue;
    assign mem_rd_addr = rq_head.addr[MEM_AW+2:3] + MEM_AW'(beat_idx);

    // Request FIFO still holds an entry after this edge -> keep issuing, no bubble.
    assign rq_next_nonempty = (rq_count == 2'd2) || ((rq_count == 2'd1) && !rq_pop) ||
                              (rq_push_valid && rq_push_ready);

    assign pop_eff = sdp2mcif_rd_cdt_lat_fifo_pop && (credit != CW'(LAT_DEPTH));

    assign rsp_busy = rq_valid || (state == ST_ISSUE) || rd_pending || mcif2sdp_rd_rsp_valid;

    // Address bits below the 8-byte beat and above the SRAM range carry no information here.
    assign unused_addr_bits = ^{rq_head.addr[REQ_ADDR_W-1:MEM_AW+3], rq_head.addr[2:0]};

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state      <= ST_IDLE;
            beat_idx   <= '0;
            rd_pending <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            init_done  <= 1'b1;
            rd_pending <= issue;
            if (issue) beat_idx <= last_beat ? '0 : beat_idx + REQ_SIZE_W'(1);
            state <= rq_next_nonempty ? ST_ISSUE : ST_IDLE;
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            credit <= CW'(LAT_DEPTH);
        end else begin
            case ({issue, pop_eff})
                2'b10:   credit <= credit - CW'(1);
                2'b01:   credit <= credit + CW'(1);
                default: credit <= credit;
            endcase
        end
    end

    a_credit_no_overflow : assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        !(sdp2mcif_rd_cdt_lat_fifo_pop && (credit == CW'(LAT_DEPTH))))
        else $error("credit pop received with the credit pool already full");

    a_rsp_never_overrun : assert property (@(posedge nvdla_core_clk) disable iff (nvdla_core_rst)
        !(rd_pending && !rsp_push_ready))
        else $error("SRAM beat arrived with the output buffer full");

endmodule

// File: tb/tb_sdp_mcif_rd_responder.sv
module tb_sdp_mcif_rd_responder;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [46:0] req_pd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [64:0] rsp_pd;
    logic        cdt_pop;
    logic        mem_rd_en;
    logic [15:0] mem_rd_addr;
    logic [63:0] mem_rd_data;
    logic        rsp_busy;

    sdp_mcif_rd_responder #(.LAT_DEPTH(4), .MEM_AW(16)) dut (
        .nvdla_core_clk               (clk),
        .nvdla_core_rst               (rst),
        .sdp2mcif_rd_req_valid        (req_valid),
        .sdp2mcif_rd_req_ready        (req_ready),
        .sdp2mcif_rd_req_pd           (req_pd),
        .mcif2sdp_rd_rsp_valid        (rsp_valid),
        .mcif2sdp_rd_rsp_ready        (rsp_ready),
        .mcif2sdp_rd_rsp_pd           (rsp_pd),
        .sdp2mcif_rd_cdt_lat_fifo_pop (cdt_pop),
        .mem_rd_en                    (mem_rd_en),
        .mem_rd_addr                  (mem_rd_addr),
        .mem_rd_data                  (mem_rd_data),
        .rsp_busy                     (rsp_busy)
    );

    int nchk  = 0;
    int npass = 0;
    int cyc   = 0;

    // stimulus controls
    bit       rdy_rand = 0;
    bit       auto_cdt = 1;
    bit       man_pop  = 0;
    bit [7:0] lfsr     = 8'hA5;
    int       acc_cyc  = 0;

    // monitors
    logic [64:0] got_pd[$];
    int          got_cyc[$];
    logic [15:0] iss_addr[$];
    int          iss_cyc[$];
    int          first_vld_cyc = -1;
    int          stalls = 0;
    bit          stall_prev = 0;
    logic [64:0] prev_pd = '0;

    typedef struct {
        logic [31:0] addr;
        logic [14:0] size;
        int          beats;
        logic [15:0] first;
        logic [15:0] last;
    } vec_t;
    vec_t vt[6];

    function automatic logic [63:0] sram_word(input logic [15:0] a);
        return {16'hCAFE, a, ~a, a};
    endfunction

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // synchronous SRAM model: data valid one cycle after the read enable
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= sram_word(mem_rd_addr);
    end

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 0;
        end else begin
            if (mem_rd_en) begin
                iss_addr.push_back(mem_rd_addr);
                iss_cyc.push_back(cyc);
            end
            if (rsp_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
            if (stall_prev) check("pd_stable_while_stalled", {rsp_valid, rsp_pd}, {1'b1, prev_pd});
            if (rsp_valid && rsp_ready) begin
                got_pd.push_back(rsp_pd);
                got_cyc.push_back(cyc);
            end
            if (rsp_valid && !rsp_ready) stalls++;
            stall_prev = rsp_valid && !rsp_ready;
            prev_pd    = rsp_pd;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rdy_rand) begin
            lfsr      = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            rsp_ready = lfsr[0];
        end else begin
            rsp_ready = 1'b1;
        end
        cdt_pop = man_pop || (auto_cdt && rsp_valid && rsp_ready);
    endtask

    task automatic clear_mon();
        got_pd.delete();
        got_cyc.delete();
        iss_addr.delete();
        iss_cyc.delete();
        first_vld_cyc = -1;
        stalls = 0;
    endtask

    task automatic send(input logic [31:0] addr, input logic [14:0] size);
        int t = 0;
        req_pd    = {size, addr};
        req_valid = 1'b1;
        while (!req_ready && t < 50) begin
            tick();
            t++;
        end
        if (!req_ready) begin
            check("req_accept_timeout", 96'd0, 96'd1);
        end else begin
            tick();
            acc_cyc = cyc;
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_beats(input int n, input int budget);
        for (int t = 0; t < budget && got_pd.size() < n; t++) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad;
        int n0;
        int ni0;
        logic [15:0] a;
        logic [15:0] exp31[6];

        vt[0] = '{32'h0000_0100, 15'd0,      1,     16'h0020, 16'h0020};
        vt[1] = '{32'h0000_0000, 15'd3,      4,     16'h0000, 16'h0003};
        vt[2] = '{32'h0007_FFF0, 15'd3,      4,     16'hFFFE, 16'h0001};
        vt[3] = '{32'h1234_5678, 15'd1,      2,     16'h8ACF, 16'h8AD0};
        vt[4] = '{32'h0008_0000, 15'd5,      6,     16'h0000, 16'h0005};
        vt[5] = '{32'h0000_0000, 15'h7FFF,   32768, 16'h0000, 16'h7FFF};

        rst = 1; req_valid = 0; req_pd = '0; rsp_ready = 1; cdt_pop = 0; mem_rd_data = '0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready",   {95'd0, req_ready},  96'd0);
        check("rst_rsp_valid",   {95'd0, rsp_valid},  96'd0);
        check("rst_rsp_pd",      {31'd0, rsp_pd},     96'd0);
        check("rst_mem_rd_en",   {95'd0, mem_rd_en},  96'd0);
        check("rst_mem_rd_addr", {80'd0, mem_rd_addr}, 96'd0);
        check("rst_busy",        {95'd0, rsp_busy},   96'd0);
        check("rst_credit",      96'(dut.credit),     96'd4);
        rst = 0;
        #1;
        check("req_ready_before_first_edge", {95'd0, req_ready}, 96'd0);
        tick();
        check("req_ready_after_release", {95'd0, req_ready}, 96'd1);

        // table-driven single requests, ready high, credits returned per beat
        for (int v = 0; v < 6; v++) begin
            clear_mon();
            send(vt[v].addr, vt[v].size);
            wait_beats(vt[v].beats, vt[v].beats + 100);
            repeat (3) tick();
            check($sformatf("v%0d_beats", v), 96'(got_pd.size()), 96'(vt[v].beats));
            check($sformatf("v%0d_issues", v), 96'(iss_addr.size()), 96'(vt[v].beats));
            check($sformatf("v%0d_latency", v), 96'(first_vld_cyc - acc_cyc), 96'd2);
            if (got_pd.size() > 0) begin
                check($sformatf("v%0d_first_addr", v), 96'(got_pd[0][15:0]), 96'(vt[v].first));
                check($sformatf("v%0d_last_addr", v), 96'(got_pd[got_pd.size()-1][15:0]), 96'(vt[v].last));
            end
            bad = 0;
            a = vt[v].first;
            for (int i = 0; i < got_pd.size(); i++) begin
                if (got_pd[i] !== {1'b1, sram_word(a)}) bad++;
                if (i >= iss_addr.size() || iss_addr[i] !== a) bad++;
                a = a + 16'd1;
            end
            check($sformatf("v%0d_beat_content", v), 96'(bad), 96'd0);
            check($sformatf("v%0d_busy_idle", v), {95'd0, rsp_busy}, 96'd0);
        end

        // credit starvation: size 7 with only 4 credits, then return 4 credits
        clear_mon();
        auto_cdt = 0;
        send(32'h0, 15'd7);
        repeat (20) tick();
        check("cdt_issued_before_stall", 96'(iss_addr.size()), 96'd4);
        check("cdt_beats_before_stall", 96'(got_pd.size()), 96'd4);
        check("cdt_credit_exhausted", 96'(dut.credit), 96'd0);
        check("cdt_busy_while_stalled", {95'd0, rsp_busy}, 96'd1);
        man_pop = 1;
        repeat (4) tick();
        man_pop = 0;
        tick();
        wait_beats(8, 30);
        check("cdt_beats_total", 96'(got_pd.size()), 96'd8);
        bad = 0;
        for (int i = 0; i < got_pd.size(); i++)
            if (got_pd[i][15:0] !== 16'(i)) bad++;
        check("cdt_beat_order", 96'(bad), 96'd0);
        repeat (3) tick();
        check("cdt_credit_after_drain", 96'(dut.credit), 96'd0);
        man_pop = 1;
        repeat (4) tick();
        man_pop = 0;
        tick();
        check("cdt_credit_restored", 96'(dut.credit), 96'd4);
        auto_cdt = 1;

        // back-to-back requests: size 3 @0x200 then size 1 @0x400
        clear_mon();
        exp31 = '{16'h0040, 16'h0041, 16'h0042, 16'h0043, 16'h0080, 16'h0081};
        send(32'h200, 15'd3);
        send(32'h400, 15'd1);
        wait_beats(6, 50);
        repeat (3) tick();
        check("b2b_beats", 96'(got_pd.size()), 96'd6);
        bad = 0;
        for (int i = 0; i < 6; i++)
            if (i >= got_pd.size() || got_pd[i][15:0] !== exp31[i]) bad++;
        check("b2b_order", 96'(bad), 96'd0);
        check("b2b_issue_span",  96'((iss_cyc.size() == 6) ? iss_cyc[5] - iss_cyc[0] : -1), 96'd5);
        check("b2b_output_span", 96'((got_cyc.size() == 6) ? got_cyc[5] - got_cyc[0] : -1), 96'd5);

        // random ready over a 16-beat burst
        clear_mon();
        rdy_rand = 1;
        send(32'h1000, 15'd15);
        wait_beats(16, 300);
        rdy_rand = 0;
        repeat (3) tick();
        check("bp_beats", 96'(got_pd.size()), 96'd16);
        bad = 0;
        for (int i = 0; i < got_pd.size(); i++)
            if (got_pd[i] !== {1'b1, sram_word(16'h0200 + 16'(i))}) bad++;
        check("bp_content", 96'(bad), 96'd0);
        check("bp_stalls_seen", {95'd0, stalls > 0}, 96'd1);

        // reset in the middle of a size-9 burst
        clear_mon();
        send(32'h0, 15'd9);
        wait_beats(3, 50);
        n0  = got_pd.size();
        ni0 = iss_addr.size();
        rst = 1;
        #1;
        check("mid_rst_rsp_valid", {95'd0, rsp_valid},   96'd0);
        check("mid_rst_rsp_pd",    {31'd0, rsp_pd},      96'd0);
        check("mid_rst_mem_rd_en", {95'd0, mem_rd_en},   96'd0);
        check("mid_rst_mem_addr",  {80'd0, mem_rd_addr}, 96'd0);
        check("mid_rst_req_ready", {95'd0, req_ready},   96'd0);
        check("mid_rst_busy",      {95'd0, rsp_busy},    96'd0);
        check("mid_rst_credit",    96'(dut.credit),      96'd4);
        repeat (2) tick();
        rst = 0;
        repeat (30) tick();
        check("post_rst_no_beats",  96'(got_pd.size()),   96'(n0));
        check("post_rst_no_issues", 96'(iss_addr.size()), 96'(ni0));
        check("post_rst_busy",      {95'd0, rsp_busy},    96'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
